// File: rtl/aes_block_packer.sv
// aes_block_packer
//
// Input-side staging block for the AES decryptor. 16-bit ciphertext words
// from the CPU write path are packed big-endian into a 128-bit assembly
// register. Each completed block moves to an output register and is
// presented to the decryptor over a valid/ready handshake. Because the
// assembly and output registers are separate, the CPU can fill the next
// block while the decryptor still holds the current one. At most two
// blocks are buffered.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous, active-high reset
//   word_i         16-bit ciphertext word from the CPU
//   word_v_i       word_i valid
//   word_ready_o   packer can accept a word this cycle
//   clear_i        synchronous abort; drops the partial and held blocks
//   block_o        packed 128-bit block; word 0 sits in block_o[127:112]
//   block_v_o      block_o valid
//   block_ready_i  decryptor ready; a block transfers on valid & ready
//   fill_cnt_o     words currently held in the assembly register (0..8)

module aes_block_packer #(
    parameter int word_width_p      = 16,
    parameter int words_per_block_p = 8
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [word_width_p-1:0]                   word_i,
    input  logic                                      word_v_i,
    output logic                                      word_ready_o,
    input  logic                                      clear_i,
    output logic [word_width_p*words_per_block_p-1:0] block_o,
    output logic                                      block_v_o,
    input  logic                                      block_ready_i,
    output logic [3:0]                                fill_cnt_o
);

    localparam int block_width_lp = word_width_p * words_per_block_p;

    logic [block_width_lp-1:0] asm_r;
    logic [block_width_lp-1:0] out_r;
    logic [3:0]                cnt_r;
    logic                      out_full_r;

    logic                      word_fire;
    logic                      slot_free;
    logic                      completing;
    logic                      holding;
    logic                      load;
    logic                      consume;
    logic [block_width_lp-1:0] asm_next;

    assign word_ready_o = (cnt_r < 4'(words_per_block_p)) & ~clear_i;
    assign word_fire    = word_v_i & word_ready_o;
    assign slot_free    = ~out_full_r | block_ready_i;
    assign completing   = word_fire & (cnt_r == 4'(words_per_block_p - 1));
    assign holding      = (cnt_r == 4'(words_per_block_p));
    assign load         = slot_free & (completing | holding);
    assign consume      = out_full_r & block_ready_i;

    assign block_o    = out_r;
    assign block_v_o  = out_full_r;
    assign fill_cnt_o = cnt_r;

    // Assembly register with the incoming word merged into slot cnt_r.
    // Feeding this merged value to the output register lets the eighth
    // word reach block_o on the same edge it is accepted. While a full
    // block is held no word can fire, so this equals asm_r in that case.
    always_comb begin
        asm_next = asm_r;
        for (int k = 0; k < words_per_block_p; k++) begin
            if (word_fire && (cnt_r == 4'(k))) begin
                asm_next[(words_per_block_p-1-k)*word_width_p +: word_width_p] = word_i;
            end
        end
    end

    // Storage update. clear_i overrides everything else. A load takes
    // priority over a consume, so a block completing in the same cycle
    // the previous one leaves keeps block_v_o high without a bubble.
    // Without a load, a consume drops valid on the very next cycle,
    // because the decryptor counts every cycle its valid input is high.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            asm_r      <= '0;
            out_r      <= '0;
            cnt_r      <= '0;
            out_full_r <= 1'b0;
        end else if (clear_i) begin
            cnt_r      <= '0;
            out_full_r <= 1'b0;
        end else begin
            if (word_fire) begin
                asm_r <= asm_next;
            end
            if (load) begin
                out_r      <= asm_next;
                out_full_r <= 1'b1;
                cnt_r      <= '0;
            end else begin
                if (completing) begin
                    cnt_r <= 4'(words_per_block_p);
                end else if (word_fire) begin
                    cnt_r <= cnt_r + 4'd1;
                end
                if (consume) begin
                    out_full_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer
//
// Directed testbench for aes_block_packer. Inputs change 1 time unit after
// the rising clock edge, and outputs are sampled 1 time unit after that.
// Expected blocks are built from the same word sequences the bench drives.

module tb_aes_block_packer;

    logic         clk_i;
    logic         reset_i;
    logic [15:0]  word_i;
    logic         word_v_i;
    logic         word_ready_o;
    logic         clear_i;
    logic [127:0] block_o;
    logic         block_v_o;
    logic         block_ready_i;
    logic [3:0]   fill_cnt_o;

    int tests;
    int failures;

    logic [127:0] exp_blk;
    logic [127:0] exp_blk2;
    logic [15:0]  w;

    aes_block_packer #(
        .word_width_p      (16),
        .words_per_block_p (8)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .word_i        (word_i),
        .word_v_i      (word_v_i),
        .word_ready_o  (word_ready_o),
        .clear_i       (clear_i),
        .block_o       (block_o),
        .block_v_o     (block_v_o),
        .block_ready_i (block_ready_i),
        .fill_cnt_o    (fill_cnt_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive all handshake inputs together, then settle one time unit so
    // combinational outputs can be sampled.
    task automatic applyStimulus(input logic v, input logic [15:0] data,
                                 input logic rdy, input logic clr);
        word_v_i      = v;
        word_i        = data;
        block_ready_i = rdy;
        clear_i       = clr;
        #1;
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One comparison; a mismatch is counted and reported.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, basic packing, backpressure, streaming,
    // clear and asynchronous reset.
    initial begin
        tests         = 0;
        failures      = 0;
        reset_i       = 1'b1;
        word_i        = '0;
        word_v_i      = 1'b0;
        clear_i       = 1'b0;
        block_ready_i = 1'b0;

        // Reset state.
        #3;
        checkOutput("rst_block", block_o, 128'h0);
        checkOutput("rst_valid", {127'h0, block_v_o}, 128'h0);
        checkOutput("rst_fill", {124'h0, fill_cnt_o}, 128'h0);
        tick();
        reset_i = 1'b0;
        #1;
        checkOutput("rst_ready", {127'h0, word_ready_o}, 128'h1);

        // Basic block: 0x0011, 0x2233, ... 0xEEFF with block_ready_i high.
        for (int i = 0; i < 8; i++) begin
            w = {8'((2*i)*17), 8'((2*i+1)*17)};
            applyStimulus(1'b1, w, 1'b1, 1'b0);
            checkOutput("basic_valid_pre", {127'h0, block_v_o}, 128'h0);
            tick();
            checkOutput("basic_fill", {124'h0, fill_cnt_o},
                        (i < 7) ? 128'(i + 1) : 128'h0);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("basic_valid", {127'h0, block_v_o}, 128'h1);
        checkOutput("basic_block", block_o, 128'h00112233445566778899AABBCCDDEEFF);
        tick();
        checkOutput("basic_valid_drop", {127'h0, block_v_o}, 128'h0);

        // Backpressure: 20 words with block_ready_i low, 16 fit.
        for (int k = 0; k < 8; k++) begin
            exp_blk[127-16*k -: 16]  = 16'h1000 + 16'(k);
            exp_blk2[127-16*k -: 16] = 16'h1000 + 16'(k + 8);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
            checkOutput("bp_ready", {127'h0, word_ready_o}, (i < 16) ? 128'h1 : 128'h0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("bp_fill", {124'h0, fill_cnt_o}, 128'h8);
        checkOutput("bp_valid", {127'h0, block_v_o}, 128'h1);
        checkOutput("bp_block1", block_o, exp_blk);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("bp_valid2", {127'h0, block_v_o}, 128'h1);
        checkOutput("bp_block2", block_o, exp_blk2);
        checkOutput("bp_fill_after", {124'h0, fill_cnt_o}, 128'h0);
        checkOutput("bp_ready_after", {127'h0, word_ready_o}, 128'h1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_drained", {127'h0, block_v_o}, 128'h0);

        // Back-to-back 24 words: one-cycle valid pulse every 8 cycles.
        for (int i = 0; i < 24; i++) begin
            exp_blk[127-16*(i%8) -: 16] = 16'hA000 + 16'(i);
            applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0);
            tick();
            checkOutput("b2b_valid", {127'h0, block_v_o}, (i % 8 == 7) ? 128'h1 : 128'h0);
            if (i % 8 == 7) begin
                checkOutput("b2b_block", block_o, exp_blk);
            end
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_tail", {127'h0, block_v_o}, 128'h0);

        // Clear after 5 words drops the partial block and the cleared word.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'hB000 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        checkOutput("clr_fill_pre", {124'h0, fill_cnt_o}, 128'h5);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b1);
        checkOutput("clr_ready", {127'h0, word_ready_o}, 128'h0);
        tick();
        checkOutput("clr_fill", {124'h0, fill_cnt_o}, 128'h0);
        checkOutput("clr_valid", {127'h0, block_v_o}, 128'h0);
        for (int i = 0; i < 8; i++) begin
            exp_blk[127-16*i -: 16] = 16'hC000 + 16'(i);
            applyStimulus(1'b1, 16'hC000 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("clr_next_valid", {127'h0, block_v_o}, 128'h1);
        checkOutput("clr_next_block", block_o, exp_blk);

        // Held block stays stable while not consumed.
        tick();
        checkOutput("hold_valid", {127'h0, block_v_o}, 128'h1);
        checkOutput("hold_block", block_o, exp_blk);

        // Asynchronous reset mid-block with valid high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("arst_fill_pre", {124'h0, fill_cnt_o}, 128'h3);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("arst_valid", {127'h0, block_v_o}, 128'h0);
        checkOutput("arst_fill", {124'h0, fill_cnt_o}, 128'h0);
        checkOutput("arst_block", block_o, 128'h0);
        tick();
        reset_i = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("arst_ready", {127'h0, word_ready_o}, 128'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
